slave_mem_model: RTL and testbench
==================================

SLAVE_MEM_MODEL -- requirements
Module: slave_mem_model

Interface
REQ-001 SHALL have parameter SLAVE_N, default cross_bar_pkg::SLAVE_N, number of independent slave channels.
REQ-002 SHALL have parameter ADDR_W, default cross_bar_pkg::ADDR_W, address width.
REQ-003 SHALL have parameter DATA_W, default cross_bar_pkg::DATA_W, data width.
REQ-004 SHALL have parameter MEM_DEPTH, default 256, words per channel, power of two, at least 2.
REQ-005 SHALL have parameter ACK_LAT, default 2, range 0..15, wait cycles before ack.
REQ-006 SHALL have parameter RAND_WAIT, default 0; value 1 enables pseudo-random wait states.
REQ-007 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-008 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-009 SHALL have ports: slave_req  in  SLAVE_N  per-channel request, held until ack.
REQ-010 SHALL have ports: slave_addr  in  SLAVE_N x addr_t  per-channel address.
REQ-011 SHALL have ports: slave_cmd  in  SLAVE_N  per-channel command, 1 = write, 0 = read.
REQ-012 SHALL have ports: slave_wdata  in  SLAVE_N x data_t  per-channel write data.
REQ-013 SHALL have ports: slave_ack  out  SLAVE_N  per-channel one-cycle acknowledge.
REQ-014 SHALL have ports: slave_rdata  out  SLAVE_N x data_t  per-channel read data.
REQ-015 SHALL have ports: txn_cnt  out  SLAVE_N x 16  per-channel completed-transaction count, saturating.
REQ-016 SHALL have ports: proto_err  out  SLAVE_N  per-channel sticky protocol-violation flag.

Function
REQ-017 SHALL give each channel an independent FSM with states IDLE, WAIT, ACK; channels SHALL NOT interact.
REQ-018 In IDLE with slave_req=1 at edge t: SHALL latch addr, cmd and wdata, load the wait counter W, and enter WAIT if W>0, otherwise ACK.
REQ-019 W SHALL equal ACK_LAT when RAND_WAIT=0; when RAND_WAIT=1, W SHALL equal lfsr[3:0] mod (ACK_LAT+1).
REQ-020 WAIT SHALL decrement the counter each cycle and enter ACK when the counter reaches 1; slave_ack SHALL be high only in ACK, so ack asserts at cycle t+1+W.
REQ-021 ACK SHALL last exactly one cycle and then return to IDLE; a req still high in the following IDLE cycle SHALL start a new transaction, giving at most one transaction per W+2 cycles.
REQ-022 Memory index SHALL be the latched addr[log2(MEM_DEPTH)-1:0]; higher address bits SHALL alias, and index MEM_DEPTH-1 SHALL wrap to 0.
REQ-023 A write SHALL update memory at the ACK-cycle edge using the latched wdata.
REQ-024 For a read, slave_rdata SHALL present mem[index] during the ACK cycle and hold that value until the next read ack; writes SHALL NOT change slave_rdata.
REQ-025 A read in the cycle after a write ack to the same index SHALL return the new data.
REQ-026 txn_cnt SHALL increment on each ack and saturate at 16'hFFFF.
REQ-027 proto_err SHALL set if, in WAIT, slave_req=0, or addr, cmd or wdata differs from the latched value; it SHALL stay set until reset, and the transaction SHALL still complete using the latched values.
REQ-028 Each channel SHALL have a 16-bit Fibonacci LFSR (taps 16,14,13,11) seeded 16'hACE1 XOR channel index, advancing every cycle outside reset.

Reset
REQ-029 While reset=1: all FSMs SHALL be in IDLE, slave_ack=0, slave_rdata=0, txn_cnt=0, proto_err=0, and each LFSR SHALL be at its seed.
REQ-030 Reset asserted mid-transaction SHALL abort it with no memory write and no ack.
REQ-031 Memory contents SHALL NOT be reset.

Structure
REQ-032 SLAVE_N, ADDR_W, DATA_W, addr_t and data_t SHALL come from cross_bar_pkg; the FSM state enum typedef SHALL be added to cross_bar_pkg.
REQ-033 Per-channel logic SHALL be one sub-module, slave_mem_chan, instantiated SLAVE_N times with a generate loop.

Verification
REQ-034 With ACK_LAT=2 and RAND_WAIT=0: write 32'hDEADBEEF to addr 0x10 on channel 0 -> ack at t+3; a following read of 0x10 -> rdata 32'hDEADBEEF with ack; txn_cnt[0]=2.
REQ-035 With MEM_DEPTH=256: write 0x55 to addr 0x105, then read addr 0x005 -> 0x55 (aliasing).
REQ-036 Drop req during WAIT on channel 1 -> proto_err[1]=1 and ack still issued; other channels' proto_err stays 0.
REQ-037 Issue simultaneous requests on all SLAVE_N channels with distinct data -> each acks at t+1+ACK_LAT and read-back matches per channel.
REQ-038 Assert reset for 1 cycle during WAIT of a write to 0x20 -> no ack, txn_cnt=0, and mem[0x20] unchanged.
REQ-039 With RAND_WAIT=1 and ACK_LAT=3: 1000 back-to-back reads -> every ack-to-request distance is within 1..4 cycles, and the wait distribution matches a reference LFSR model.

Source files
------------

// File: rtl/cross_bar_pkg.sv
// Shared crossbar types and constants used by the slave memory model.
package cross_bar_pkg;

    localparam int SLAVE_N = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } slave_state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

endpackage

// File: rtl/slave_mem_chan.sv
// One slave channel: request handshake FSM with wait states, private memory,
// transaction counter, sticky protocol-error flag and wait-state LFSR.
module slave_mem_chan #(
    parameter int ADDR_W    = cross_bar_pkg::ADDR_W,
    parameter int DATA_W    = cross_bar_pkg::DATA_W,
    parameter int MEM_DEPTH = 256,
    parameter int ACK_LAT   = 2,
    parameter int RAND_WAIT = 0,
    parameter int CHAN_IDX  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    input  logic              cmd,
    input  logic [DATA_W-1:0] wdata,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic [15:0]       txn_cnt,
    output logic              proto_err
);

    localparam int          IDX_W = $clog2(MEM_DEPTH);
    localparam logic [15:0] SEED  = cross_bar_pkg::LFSR_SEED ^ 16'(CHAN_IDX);

    cross_bar_pkg::slave_state_e r_state, w_state_next;

    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_cmd;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [15:0]       r_txn_cnt;
    logic              r_proto_err;
    logic [15:0]       r_lfsr;
    logic [DATA_W-1:0] r_mem [MEM_DEPTH];

    logic              w_load;
    logic [3:0]        w_wait;
    logic              w_cmd_next;
    logic [IDX_W-1:0]  w_idx_next;
    logic              w_mismatch;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            cross_bar_pkg::ST_IDLE:
                if (req) w_state_next = (w_wait == 4'd0) ? cross_bar_pkg::ST_ACK : cross_bar_pkg::ST_WAIT;
            cross_bar_pkg::ST_WAIT:
                if (r_cnt == 4'd1) w_state_next = cross_bar_pkg::ST_ACK;
            cross_bar_pkg::ST_ACK:
                w_state_next = cross_bar_pkg::ST_IDLE;
            default:
                w_state_next = cross_bar_pkg::ST_IDLE;
        endcase
    end

    always_comb begin
        if (RAND_WAIT == 1) w_wait = 4'({28'd0, r_lfsr[3:0]} % (ACK_LAT + 1));
        else                w_wait = 4'(ACK_LAT);
    end

    // A zero-wait request goes straight to ACK, so the read index may come from the live address.
    assign w_load     = (r_state == cross_bar_pkg::ST_IDLE) && req;
    assign w_cmd_next = w_load ? cmd : r_cmd;
    assign w_idx_next = w_load ? addr[IDX_W-1:0] : r_addr[IDX_W-1:0];
    assign w_mismatch = !req || (addr != r_addr) || (cmd != r_cmd) || (wdata != r_wdata);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= cross_bar_pkg::ST_IDLE;
            r_cnt       <= 4'd0;
            r_addr      <= '0;
            r_cmd       <= 1'b0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_txn_cnt   <= 16'd0;
            r_proto_err <= 1'b0;
            r_lfsr      <= SEED;
        end else begin
            r_state <= w_state_next;
            r_lfsr  <= cross_bar_pkg::lfsr_next(r_lfsr);
            if (w_load) begin
                r_addr  <= addr;
                r_cmd   <= cmd;
                r_wdata <= wdata;
                r_cnt   <= w_wait;
            end else if (r_state == cross_bar_pkg::ST_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (r_state == cross_bar_pkg::ST_WAIT && w_mismatch) r_proto_err <= 1'b1;
            if (r_state == cross_bar_pkg::ST_ACK && r_txn_cnt != 16'hFFFF) r_txn_cnt <= r_txn_cnt + 16'd1;
            if (w_state_next == cross_bar_pkg::ST_ACK && !w_cmd_next) r_rdata <= r_mem[w_idx_next];
        end
    end

    // NOTE: the memory array is deliberately not reset; only the write enable is gated by reset.
    always_ff @(posedge clk) begin
        if (!reset && r_state == cross_bar_pkg::ST_ACK && r_cmd) r_mem[r_addr[IDX_W-1:0]] <= r_wdata;
    end

    assign ack       = (r_state == cross_bar_pkg::ST_ACK);
    assign rdata     = r_rdata;
    assign txn_cnt   = r_txn_cnt;
    assign proto_err = r_proto_err;

endmodule

// File: rtl/slave_mem_model.sv
// Multi-channel slave memory model: SLAVE_N independent channels with
// configurable fixed or pseudo-random acknowledge latency.
module slave_mem_model #(
    parameter int SLAVE_N   = cross_bar_pkg::SLAVE_N,
    parameter int ADDR_W    = cross_bar_pkg::ADDR_W,
    parameter int DATA_W    = cross_bar_pkg::DATA_W,
    parameter int MEM_DEPTH = 256,
    parameter int ACK_LAT   = 2,
    parameter int RAND_WAIT = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [SLAVE_N-1:0]             slave_req,
    input  logic [SLAVE_N-1:0][ADDR_W-1:0] slave_addr,
    input  logic [SLAVE_N-1:0]             slave_cmd,
    input  logic [SLAVE_N-1:0][DATA_W-1:0] slave_wdata,
    output logic [SLAVE_N-1:0]             slave_ack,
    output logic [SLAVE_N-1:0][DATA_W-1:0] slave_rdata,
    output logic [SLAVE_N-1:0][15:0]       txn_cnt,
    output logic [SLAVE_N-1:0]             proto_err
);

    for (genvar i = 0; i < SLAVE_N; i++) begin : g_chan
        slave_mem_chan #(
            .ADDR_W   (ADDR_W),
            .DATA_W   (DATA_W),
            .MEM_DEPTH(MEM_DEPTH),
            .ACK_LAT  (ACK_LAT),
            .RAND_WAIT(RAND_WAIT),
            .CHAN_IDX (i)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .req      (slave_req[i]),
            .addr     (slave_addr[i]),
            .cmd      (slave_cmd[i]),
            .wdata    (slave_wdata[i]),
            .ack      (slave_ack[i]),
            .rdata    (slave_rdata[i]),
            .txn_cnt  (txn_cnt[i]),
            .proto_err(proto_err[i])
        );
    end

endmodule

// File: tb/tb_slave_mem_model.sv
// Self-checking bench: directed vectors on a fixed-latency instance and
// randomized reads on a random-wait instance against an LFSR reference.
module tb_slave_mem_model;

    localparam int N    = cross_bar_pkg::SLAVE_N;
    localparam int LAT  = 3;
    localparam int MAXW = 40;

    typedef struct {
        bit          cmd;
        int          ch;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        string       name;
    } vec_t;

    logic clk = 1'b0;
    logic reset;

    logic [N-1:0]        req, cmd, ack, perr;
    logic [N-1:0][31:0]  addr, wdata, rdata;
    logic [N-1:0][15:0]  txn;
    logic [N-1:0]        req_r, cmd_r, ack_r, perr_r;
    logic [N-1:0][31:0]  addr_r, wdata_r, rdata_r;
    logic [N-1:0][15:0]  txn_r;

    int total = 0;
    int bad   = 0;
    logic [15:0] m_lfsr = 16'hACE1;

    always #5 clk = ~clk;

    slave_mem_model dut (
        .clk(clk), .reset(reset), .slave_req(req), .slave_addr(addr), .slave_cmd(cmd),
        .slave_wdata(wdata), .slave_ack(ack), .slave_rdata(rdata), .txn_cnt(txn), .proto_err(perr)
    );

    slave_mem_model #(.ACK_LAT(3), .RAND_WAIT(1)) dut_r (
        .clk(clk), .reset(reset), .slave_req(req_r), .slave_addr(addr_r), .slave_cmd(cmd_r),
        .slave_wdata(wdata_r), .slave_ack(ack_r), .slave_rdata(rdata_r), .txn_cnt(txn_r), .proto_err(perr_r)
    );

    // Reference LFSR: XOR of tap bits 16,14,13,11 shifted in at the top.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {^(s & 16'h002D), s[15:1]};
    endfunction

    task automatic tick();
        @(posedge clk);
        m_lfsr = reset ? 16'hACE1 : lfsr_step(m_lfsr);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Single transaction; lat = ticks from request to ack (0 if ack never came).
    task automatic do_txn(input bit rnd, input int ch, input bit c, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rd, output int lat);
        bit got;
        got = 1'b0;
        lat = 0;
        rd  = '0;
        if (rnd) begin req_r[ch] = 1'b1; cmd_r[ch] = c; addr_r[ch] = a; wdata_r[ch] = d; end
        else     begin req[ch]   = 1'b1; cmd[ch]   = c; addr[ch]   = a; wdata[ch]   = d; end
        for (int n = 1; n <= MAXW && !got; n++) begin
            tick();
            if (rnd ? ack_r[ch] : ack[ch]) begin
                got = 1'b1;
                lat = n;
                rd  = rnd ? rdata_r[ch] : rdata[ch];
            end
        end
        if (rnd) req_r[ch] = 1'b0;
        else     req[ch]   = 1'b0;
        tick();
    endtask

    // Write whose handshake is disturbed after the first WAIT edge.
    task automatic glitch_txn(input int ch, input bit drop, input logic [31:0] a,
                              input logic [31:0] d, output int lat);
        lat = 0;
        req[ch] = 1'b1; cmd[ch] = 1'b1; addr[ch] = a; wdata[ch] = d;
        for (int n = 1; n <= MAXW && lat == 0; n++) begin
            tick();
            if (n == 1) begin
                if (drop) req[ch] = 1'b0;
                else      wdata[ch] = ~d;
            end
            if (ack[ch]) lat = n;
        end
        req[ch] = 1'b0;
        tick();
    endtask

    initial begin
        vec_t        vecs[10];
        logic [31:0] rd;
        int          lat;
        int          ack_at[N];
        int          done_n;
        logic [7:0]  hist;
        logic        ack_any;
        logic [31:0] mm[16];
        int          exp_lat;
        int          idx;

        reset = 1'b1;
        req = '0; cmd = '0; addr = '0; wdata = '0;
        req_r = '0; cmd_r = '0; addr_r = '0; wdata_r = '0;
        tick();
        tick();
        check("rst_ack", ack, 0);
        check("rst_rdata", rdata, 0);
        check("rst_txn", txn, 0);
        check("rst_perr", perr, 0);
        check("rst_ack_r", ack_r, 0);
        reset = 1'b0;

        vecs[0] = '{1'b1, 0, 32'h010, 32'hDEADBEEF, 32'h0,        "wr_c0_10"};
        vecs[1] = '{1'b0, 0, 32'h010, 32'h0,        32'hDEADBEEF, "rd_c0_10"};
        vecs[2] = '{1'b1, 2, 32'h105, 32'h55,       32'h0,        "wr_c2_105"};
        vecs[3] = '{1'b0, 2, 32'h005, 32'h0,        32'h55,       "rd_c2_alias"};
        vecs[4] = '{1'b1, 3, 32'h0FF, 32'hA5A5A5A5, 32'h0,        "wr_c3_ff"};
        vecs[5] = '{1'b1, 3, 32'h100, 32'h12345678, 32'h0,        "wr_c3_100"};
        vecs[6] = '{1'b0, 3, 32'h1FF, 32'h0,        32'hA5A5A5A5, "rd_c3_top"};
        vecs[7] = '{1'b0, 3, 32'h000, 32'h0,        32'h12345678, "rd_c3_wrap"};
        vecs[8] = '{1'b1, 3, 32'h000, 32'hCAFEF00D, 32'h12345678, "wr_c3_hold"};
        vecs[9] = '{1'b0, 3, 32'h300, 32'h0,        32'hCAFEF00D, "rd_c3_300"};
        for (int i = 0; i < 10; i++) begin
            do_txn(1'b0, vecs[i].ch, vecs[i].cmd, vecs[i].addr, vecs[i].wdata, rd, lat);
            check({vecs[i].name, "_lat"}, lat, LAT);
            check({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
        end
        check("txn_cnt_table", txn, {16'd6, 16'd2, 16'd0, 16'd2});

        // Request held through ack restarts after one idle cycle.
        do_txn(1'b0, 1, 1'b1, 32'h05, 32'h5A5A0005, rd, lat);
        req[1] = 1'b1; cmd[1] = 1'b0; addr[1] = 32'h05;
        for (int n = 0; n < 8; n++) begin
            tick();
            hist[n] = ack[1];
        end
        req[1] = 1'b0;
        check("held_ack_pattern", hist, 8'b0100_0100);
        check("held_rdata", rdata[1], 32'h5A5A0005);
        check("held_txn", txn[1], 3);

        glitch_txn(1, 1'b1, 32'h30, 32'h0BADC0DE, lat);
        check("drop_req_lat", lat, LAT);
        check("drop_req_perr", perr, 4'b0010);
        do_txn(1'b0, 1, 1'b0, 32'h30, 32'h0, rd, lat);
        check("drop_req_data", rd, 32'h0BADC0DE);
        glitch_txn(2, 1'b0, 32'h31, 32'h11112222, lat);
        check("chg_wdata_lat", lat, LAT);
        check("chg_wdata_perr", perr, 4'b0110);
        do_txn(1'b0, 2, 1'b0, 32'h31, 32'h0, rd, lat);
        check("chg_wdata_data", rd, 32'h11112222);

        for (int c = 0; c < N; c++) begin
            req[c] = 1'b1; cmd[c] = 1'b1; addr[c] = 32'h40; wdata[c] = 32'hC0DE0000 | c;
            ack_at[c] = 0;
        end
        done_n = 0;
        for (int n = 1; n <= MAXW && done_n < N; n++) begin
            tick();
            for (int c = 0; c < N; c++) begin
                if (ack[c] && ack_at[c] == 0) begin
                    ack_at[c] = n;
                    req[c] = 1'b0;
                    done_n++;
                end
            end
        end
        req = '0;
        tick();
        for (int c = 0; c < N; c++) begin
            check($sformatf("par_lat%0d", c), ack_at[c], LAT);
            do_txn(1'b0, c, 1'b0, 32'h40, 32'h0, rd, lat);
            check($sformatf("par_rdata%0d", c), rd, 32'hC0DE0000 | c);
        end

        // Reset during WAIT aborts the write.
        do_txn(1'b0, 0, 1'b1, 32'h20, 32'h11111111, rd, lat);
        req[0] = 1'b1; cmd[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h22222222;
        tick();
        reset = 1'b1;
        tick();
        ack_any = |ack;
        reset = 1'b0;
        req = '0;
        for (int n = 0; n < 5; n++) begin
            tick();
            ack_any = ack_any | (|ack);
        end
        check("rst_mid_ack", ack_any, 1'b0);
        check("rst_mid_txn", txn, 0);
        check("rst_mid_perr", perr, 0);
        check("rst_mid_rdata", rdata, 0);
        do_txn(1'b0, 0, 1'b0, 32'h20, 32'h0, rd, lat);
        check("rst_mid_mem", rd, 32'h11111111);

        // Random-wait instance: latency follows the reference LFSR.
        for (int i = 0; i < 16; i++) begin
            mm[i]   = $urandom;
            exp_lat = int'(m_lfsr[3:0]) % 4 + 1;
            do_txn(1'b1, 0, 1'b1, ($urandom & 32'hFFFF_FF00) | i, mm[i], rd, lat);
            check("rnd_wr_lat", lat, exp_lat);
        end
        for (int k = 0; k < 1000; k++) begin
            idx     = $urandom_range(0, 15);
            exp_lat = int'(m_lfsr[3:0]) % 4 + 1;
            do_txn(1'b1, 0, 1'b0, ($urandom & 32'hFFFF_FF00) | idx, 32'h0, rd, lat);
            check("rnd_rd_lat", lat, exp_lat);
            check("rnd_rd_range", (lat >= 1 && lat <= 4), 1'b1);
            check("rnd_rd_data", rd, mm[idx]);
        end
        check("rnd_txn", txn_r[0], 16'd1016);
        check("rnd_perr", perr_r, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
